recip_ratio_mul: RTL and testbench
==================================

RECIP_RATIO_MUL -- requirements
Module: recip_ratio_mul

Interface
REQ-001 Parameter W SHALL be 32 by default: data width of all fixed-point ports.
REQ-002 Parameter F SHALL be 16 by default: fraction bits; all values are signed QF unless stated otherwise.
REQ-003 Parameter TIMEOUT_CYC SHALL be 64 by default: maximum WAIT cycles for recip_done.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  operand pair present.
REQ-007 in_ready  out  1  block accepts an operand pair.
REQ-008 num_in  in  W  signed numerator, QF.
REQ-009 den_in  in  W  signed denominator, QF.
REQ-010 recip_start  out  1  one-cycle start pulse to the reciprocal unit.
REQ-011 recip_den  out  W  positive denominator magnitude driven to the reciprocal unit.
REQ-012 recip_done  in  1  reciprocal result valid for this cycle.
REQ-013 recip_val  in  W  unsigned QF reciprocal of recip_den.
REQ-014 recip_invalid  in  1  reciprocal unit rejected its operand.
REQ-015 out_valid  out  1  result present.
REQ-016 out_ready  in  1  consumer accepts the result.
REQ-017 ratio_out  out  W  signed QF num/den.
REQ-018 ratio_err  out  1  qualified by out_valid: zero or illegal denominator, reciprocal rejection, or timeout.

Function
REQ-019 States SHALL be IDLE, REQ, WAIT, MUL, SAT, OUT; in_ready SHALL be 1 only in IDLE.
REQ-020 IDLE: when in_valid=1, capture num_in/den_in and go to REQ; if den_in is 0 or 0x80000000, go to OUT with ratio_out=0, ratio_err=1, and no recip_start.
REQ-021 REQ: recip_start=1 for exactly this cycle; recip_den=|den|; clear the timeout counter; go to WAIT.
REQ-022 recip_den SHALL be held stable from REQ until WAIT is exited.
REQ-023 WAIT: on recip_done=1, latch recip_val and go to MUL; if recip_invalid=1 as well, go to OUT with ratio_out=0, ratio_err=1.
REQ-024 WAIT: after TIMEOUT_CYC cycles without recip_done, go to OUT with ratio_out=0, ratio_err=1; a recip_done arriving later SHALL be ignored.
REQ-025 MUL: compute product = |num| (W+1 bits, unsigned) x recip_val (unsigned), 2W+1 bits unsigned; take magnitude = product >> F; sign = num[W-1] XOR den[W-1]; go to SAT.
REQ-026 SAT: form the signed result per REQ-036/037; ratio_err=0; go to OUT.
REQ-027 OUT: out_valid=1; ratio_out and ratio_err SHALL stay stable until out_ready=1, then go to IDLE the same edge.
REQ-028 Latency from accept to out_valid SHALL be 3 cycles plus the reciprocal unit's cycles, counted from REQ up to and including the recip_done cycle.
REQ-029 A zero magnitude SHALL yield ratio_out=0 regardless of sign.
REQ-030 Any state value not listed in REQ-019 SHALL transition to IDLE.

Reset
REQ-031 While rst_n=0: state=IDLE; recip_start=0, recip_den=0, out_valid=0, ratio_out=0, ratio_err=0; in_ready=0; all internal registers 0.
REQ-032 Reset asserted mid-operation SHALL abandon the transaction without emitting a result; a late recip_done after reset release SHALL be ignored in IDLE.
REQ-033 in_ready SHALL be 1 from the first clock edge after rst_n deasserts.

Configuration
REQ-034 Macro RATIO_SAT_EN SHALL select overflow handling.
REQ-035 The overflow condition SHALL be a positive magnitude > 0x7FFFFFFF or a negative magnitude > 0x80000000.
REQ-036 With RATIO_SAT_EN defined: on overflow, ratio_out SHALL clamp to 0x7FFFFFFF (positive) or 0x80000000 (negative).
REQ-037 With RATIO_SAT_EN undefined: ratio_out SHALL be the low W bits of the two's-complement signed magnitude (wrap); ratio_err SHALL not flag overflow in either build.

Verification
REQ-038 num=0x00030000 (3.0), den=0x00020000 (2.0), recip_val=0x00008000 after 5 cycles -> ratio_out=0x00018000, ratio_err=0, out_valid 8 cycles after accept.
REQ-039 num=0xFFFD0000 (-3.0), den=0x00020000, recip_val=0x00008000 -> ratio_out=0xFFFE8000; repeat with den=0xFFFE0000 and num=3.0 -> recip_den=0x00020000, ratio_out=0xFFFE8000.
REQ-040 den=0 -> no recip_start, out_valid the cycle after accept, ratio_out=0, ratio_err=1.
REQ-041 num=0x7FFF0000, den=0x00000100, recip_val=0x01000000 -> SAT build gives 0x7FFFFFFF; wrap build gives 0xFF000000.
REQ-042 No recip_done for 64 cycles -> ratio_err=1, ratio_out=0; recip_done injected later is ignored; out_ready held 0 for 10 cycles -> outputs stable throughout.
REQ-043 rst_n pulsed low during WAIT -> all outputs 0 immediately; in_ready=1 after release; subsequent transaction correct.

Source files
------------

// File: rtl/recip_ratio_mul.sv
// Signed QF divider: ratio = num * (1/|den|) using an external reciprocal unit.
// Define RATIO_SAT_EN to clamp overflowing results; otherwise the result wraps.
module recip_ratio_mul #(
  parameter int W           = 32,
  parameter int F           = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] num_in,
  input  logic [W-1:0] den_in,
  output logic         recip_start,
  output logic [W-1:0] recip_den,
  input  logic         recip_done,
  input  logic [W-1:0] recip_val,
  input  logic         recip_invalid,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] ratio_out,
  output logic         ratio_err
);

  localparam int MAG_W = 2*W + 1 - F;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
`ifdef RATIO_SAT_EN
  localparam logic [W-1:0]     MAX_POS   = {1'b0, {(W-1){1'b1}}};
  localparam logic [MAG_W-1:0] POS_LIMIT = {{(MAG_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [MAG_W-1:0] NEG_LIMIT = {{(MAG_W-W){1'b0}}, MIN_NEG};
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    MUL  = 3'd3,
    SAT  = 3'd4,
    OUT  = 3'd5
  } state_t;

  state_t state, state_nxt;

  // run_q keeps in_ready low while reset is asserted and rises on the first edge after.
  logic             run_q;
  logic [W-1:0]     num_q;
  logic             sign_q;
  logic [W-1:0]     recip_q;
  logic [CNT_W-1:0] cnt_q;
  logic [MAG_W-1:0] mag_q;

  logic             accept;
  logic             den_bad;
  logic             timeout;
  logic [W-1:0]     den_abs;
  logic [W:0]       num_ext;
  logic [W:0]       num_abs;
  logic [2*W:0]     product;
  logic [W-1:0]     signed_low;
  logic [W-1:0]     sat_result;

  assign in_ready    = run_q && (state == IDLE);
  assign recip_start = (state == REQ);
  assign out_valid   = (state == OUT);

  assign accept  = in_ready && in_valid;
  assign den_bad = (den_in == '0) || (den_in == MIN_NEG);
  assign den_abs = den_in[W-1] ? -den_in : den_in;
  assign timeout = (cnt_q == CNT_LAST) && !recip_done;

  // Magnitude of the numerator needs W+1 bits so the most negative value survives.
  assign num_ext    = {num_q[W-1], num_q};
  assign num_abs    = num_q[W-1] ? -num_ext : num_ext;
  assign product    = {{W{1'b0}}, num_abs} * {{(W+1){1'b0}}, recip_q};
  assign signed_low = sign_q ? W'(-mag_q) : W'(mag_q);

`ifdef RATIO_SAT_EN
  logic overflow;
  assign overflow   = sign_q ? (mag_q > NEG_LIMIT) : (mag_q > POS_LIMIT);
  assign sat_result = overflow ? (sign_q ? MIN_NEG : MAX_POS) : signed_low;
`else
  assign sat_result = signed_low;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets its default first so every path assigns it and no
  // latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = den_bad ? OUT : REQ;
        end
      end
      REQ:  state_nxt = WAIT;
      WAIT: begin
        if (recip_done) begin
          state_nxt = recip_invalid ? OUT : MUL;
        end else if (timeout) begin
          state_nxt = OUT;
        end
      end
      MUL:  state_nxt = SAT;
      SAT:  state_nxt = OUT;
      OUT: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      num_q     <= '0;
      sign_q    <= 1'b0;
      recip_q   <= '0;
      cnt_q     <= '0;
      mag_q     <= '0;
      recip_den <= '0;
      ratio_out <= '0;
      ratio_err <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            num_q  <= num_in;
            sign_q <= num_in[W-1] ^ den_in[W-1];
            if (den_bad) begin
              ratio_out <= '0;
              ratio_err <= 1'b1;
            end else begin
              recip_den <= den_abs;
            end
          end
        end
        REQ: cnt_q <= '0;
        WAIT: begin
          // recip_den is left untouched here so the reciprocal unit sees a stable operand.
          if (recip_done) begin
            recip_q <= recip_val;
            if (recip_invalid) begin
              ratio_out <= '0;
              ratio_err <= 1'b1;
            end
          end else if (timeout) begin
            ratio_out <= '0;
            ratio_err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        MUL: mag_q <= MAG_W'(product >> F);
        SAT: begin
          ratio_out <= sat_result;
          ratio_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_recip_ratio_mul.sv
// Self-checking bench for recip_ratio_mul: directed vector table, corner-case
// sequences (timeout, stall, mid-operation reset) and randomized traffic vs. a model.
module tb_recip_ratio_mul;

  localparam int LAT_LIMIT = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] num_in;
  logic [31:0] den_in;
  logic        recip_start;
  logic [31:0] recip_den;
  logic        recip_done;
  logic [31:0] recip_val;
  logic        recip_invalid;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ratio_out;
  logic        ratio_err;

  int checks   = 0;
  int failures = 0;

  recip_ratio_mul dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .num_in        (num_in),
    .den_in        (den_in),
    .recip_start   (recip_start),
    .recip_den     (recip_den),
    .recip_done    (recip_done),
    .recip_val     (recip_val),
    .recip_invalid (recip_invalid),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .ratio_out     (ratio_out),
    .ratio_err     (ratio_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] rv;
    bit          inv;
    int          d;
    logic [31:0] exp_sat;
    logic [31:0] exp_wrap;
    bit          exp_err;
    int          exp_lat;
    int          exp_starts;
    logic [31:0] exp_rden;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Reference: ratio from plain integer arithmetic on the operand values.
  function automatic void model(input logic [31:0] num, input logic [31:0] den,
                                input logic [31:0] rv, input bit inv, input int d,
                                output logic [31:0] res, output logic err, output int lat,
                                output int starts, output logic [31:0] rden);
    longint            sn, sd;
    longint unsigned   a, mag;
    bit                neg;
    sn = $signed(num);
    sd = $signed(den);
    rden = '0;
    if (sd == 0 || den == 32'h8000_0000) begin
      res = '0; err = 1'b1; lat = 1; starts = 0;
      return;
    end
    starts = 1;
    rden   = 32'(sd < 0 ? -sd : sd);
    if (inv) begin
      res = '0; err = 1'b1; lat = d + 2;
      return;
    end
    a   = longint'(sn < 0 ? -sn : sn);
    mag = (a * longint'(rv)) >> 16;
    neg = (sn < 0) != (sd < 0);
    err = 1'b0;
    lat = d + 4;
`ifdef RATIO_SAT_EN
    if (!neg && mag > 64'h7FFF_FFFF)     res = 32'h7FFF_FFFF;
    else if (neg && mag > 64'h8000_0000) res = 32'h8000_0000;
    else                                 res = neg ? 32'(-mag) : 32'(mag);
`else
    res = neg ? 32'(-mag) : 32'(mag);
`endif
  endfunction

  // One transaction with a reciprocal responder answering d cycles after the
  // start pulse (d < 0: never); out_ready is held low for 'hold' cycles once a
  // result appears, injecting a stray recip_done during the stall.
  task automatic run_txn(input logic [31:0] num, input logic [31:0] den, input logic [31:0] rv,
                         input bit inv, input int d, input int hold,
                         output logic [31:0] res, output logic err, output int lat,
                         output int starts, output logic [31:0] rden);
    int s;
    bit done_given;
    bit moved;
    num_in    = num;
    den_in    = den;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    step();
    in_valid = 1'b0;
    num_in   = '0;
    den_in   = '0;
    s = -1; starts = 0; rden = '0; lat = -1; res = '0; err = 1'b0;
    done_given = 1'b0; moved = 1'b0;
    for (int n = 1; n <= LAT_LIMIT; n++) begin
      if (out_valid) begin
        lat = n;
        res = ratio_out;
        err = ratio_err;
        break;
      end
      if (s >= 0 && !done_given && recip_den !== rden) moved = 1'b1;
      if (recip_start) begin
        starts++;
        if (s < 0) begin
          s    = n;
          rden = recip_den;
        end
      end
      if (s >= 0 && d >= 0 && n == s + d) begin
        recip_done    = 1'b1;
        recip_val     = rv;
        recip_invalid = inv;
        done_given    = 1'b1;
      end
      step();
      recip_done    = 1'b0;
      recip_invalid = 1'b0;
      recip_val     = '0;
    end
    if (starts > 0) check("recip_den_stable", 32'(moved), 32'd0);
    if (lat < 0) begin
      check("out_valid_timeout", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      do_reset();
      return;
    end
    for (int h = 0; h < hold; h++) begin
      if (h == 3) begin
        recip_done = 1'b1;
        recip_val  = 32'h0001_0000;
      end
      step();
      recip_done = 1'b0;
      recip_val  = '0;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_ratio", ratio_out, res);
      check("stall_err", 32'(ratio_err), 32'(err));
    end
    out_ready = 1'b1;
    step();
    check("back_to_idle", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[12];
    logic [31:0] res, rden, exp_res;
    logic [31:0] m_res, m_rden;
    logic        err, m_err;
    int          lat, starts, m_lat, m_starts;
    logic [31:0] num, den, rv;
    bit          inv;
    int          d;

    vecs[0]  = '{32'h0003_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, 4, 32'h0001_8000, 32'h0001_8000, 1'b0, 8, 1, 32'h0002_0000};
    vecs[1]  = '{32'hFFFD_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, 4, 32'hFFFE_8000, 32'hFFFE_8000, 1'b0, 8, 1, 32'h0002_0000};
    vecs[2]  = '{32'h0003_0000, 32'hFFFE_0000, 32'h0000_8000, 1'b0, 4, 32'hFFFE_8000, 32'hFFFE_8000, 1'b0, 8, 1, 32'h0002_0000};
    vecs[3]  = '{32'h0003_0000, 32'h0000_0000, 32'h0000_8000, 1'b0, 4, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0, 32'h0000_0000};
    vecs[4]  = '{32'h0003_0000, 32'h8000_0000, 32'h0000_8000, 1'b0, 4, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0, 32'h0000_0000};
    vecs[5]  = '{32'h7FFF_0000, 32'h0000_0100, 32'h0100_0000, 1'b0, 2, 32'h7FFF_FFFF, 32'hFF00_0000, 1'b0, 6, 1, 32'h0000_0100};
    vecs[6]  = '{32'h0003_0000, 32'h0002_0000, 32'h0000_8000, 1'b1, 3, 32'h0000_0000, 32'h0000_0000, 1'b1, 5, 1, 32'h0002_0000};
    vecs[7]  = '{32'h0000_0000, 32'hFFFE_0000, 32'h0000_8000, 1'b0, 1, 32'h0000_0000, 32'h0000_0000, 1'b0, 5, 1, 32'h0002_0000};
    vecs[8]  = '{32'h8000_0000, 32'h0001_0000, 32'h0001_0000, 1'b0, 1, 32'h8000_0000, 32'h8000_0000, 1'b0, 5, 1, 32'h0001_0000};
    vecs[9]  = '{32'h8000_0000, 32'hFFFF_0000, 32'h0001_0000, 1'b0, 1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 5, 1, 32'h0001_0000};
    vecs[10] = '{32'hC000_0000, 32'h0000_8000, 32'h0002_0001, 1'b0, 2, 32'h8000_0000, 32'h7FFF_C000, 1'b0, 6, 1, 32'h0000_8000};
    vecs[11] = '{32'h7FFF_FFFF, 32'h0001_0000, 32'h0001_0000, 1'b0, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 5, 1, 32'h0001_0000};

    rst_n = 1'b0; in_valid = 1'b0; num_in = '0; den_in = '0;
    recip_done = 1'b0; recip_val = '0; recip_invalid = 1'b0; out_ready = 1'b1;

    // Reset state, sampled mid-cycle with reset held.
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_recip_start", 32'(recip_start), 32'd0);
    check("rst_recip_den", recip_den, 32'd0);
    check("rst_ratio_out", ratio_out, 32'd0);
    check("rst_ratio_err", 32'(ratio_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Directed vectors.
    foreach (vecs[i]) begin
      run_txn(vecs[i].num, vecs[i].den, vecs[i].rv, vecs[i].inv, vecs[i].d, 0,
              res, err, lat, starts, rden);
`ifdef RATIO_SAT_EN
      exp_res = vecs[i].exp_sat;
`else
      exp_res = vecs[i].exp_wrap;
`endif
      check($sformatf("vec%0d_ratio", i), res, exp_res);
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_starts", i), 32'(starts), 32'(vecs[i].exp_starts));
      if (vecs[i].exp_starts > 0) check($sformatf("vec%0d_recip_den", i), rden, vecs[i].exp_rden);
    end

    // Timeout, stalled consumer and a stray recip_done during the stall.
    run_txn(32'h0003_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, -1, 10, res, err, lat, starts, rden);
    check("timeout_ratio", res, 32'd0);
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_latency", 32'(lat), 32'd66);
    check("timeout_starts", 32'(starts), 32'd1);

    // Reset asserted while waiting for the reciprocal.
    num_in = 32'h0003_0000; den_in = 32'h0002_0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("mid_req_start", 32'(recip_start), 32'd1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_start", 32'(recip_start), 32'd0);
    check("mid_rst_den", recip_den, 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_ratio", ratio_out, 32'd0);
    check("mid_rst_err", 32'(ratio_err), 32'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("mid_rel_ready", 32'(in_ready), 32'd1);
    recip_done = 1'b1; recip_val = 32'h0000_8000;
    step();
    recip_done = 1'b0; recip_val = '0;
    check("late_done_valid", 32'(out_valid), 32'd0);
    check("late_done_ready", 32'(in_ready), 32'd1);
    run_txn(32'h0003_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, 4, 0, res, err, lat, starts, rden);
    check("post_rst_ratio", res, 32'h0001_8000);
    check("post_rst_err", 32'(err), 32'd0);
    check("post_rst_latency", 32'(lat), 32'd8);

    // Randomized traffic against the model.
    for (int t = 0; t < 30; t++) begin
      num = $urandom;
      if ($urandom_range(0, 1) == 1) num = 32'($signed(num) >>> 12);
      case ($urandom_range(0, 9))
        0:       den = 32'h0000_0000;
        1:       den = 32'h8000_0000;
        2, 3:    den = $urandom_range(1, 32'h0003_0000);
        4:       den = -$urandom_range(1, 32'h0003_0000);
        default: den = $urandom;
      endcase
      rv  = $urandom >> $urandom_range(0, 24);
      inv = ($urandom_range(0, 7) == 0);
      d   = $urandom_range(1, 12);
      model(num, den, rv, inv, d, m_res, m_err, m_lat, m_starts, m_rden);
      run_txn(num, den, rv, inv, d, 0, res, err, lat, starts, rden);
      check($sformatf("rnd%0d_ratio", t), res, m_res);
      check($sformatf("rnd%0d_err", t), 32'(err), 32'(m_err));
      check($sformatf("rnd%0d_latency", t), 32'(lat), 32'(m_lat));
      check($sformatf("rnd%0d_starts", t), 32'(starts), 32'(m_starts));
      if (m_starts > 0) check($sformatf("rnd%0d_recip_den", t), rden, m_rden);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
